mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one slow-memory line port between the read-only I-cache refill path and the read/write D-cache refill/write-back path. Sits in CHIP between the cache `mem_*` ports and a single external memory port. Serves one whole-line transaction at a time, holds the granted request in registers for its full duration, and routes `mem_ready` back only to the granted requester.

## Interface
- `ADDR_W`, 28, line address width (byte address bits [31:4])
- `DATA_W`, 128, line width in bits

Ports:
- `clk` in 1: clock, rising edge
- `proc_reset` in 1: synchronous, active-high reset
- `memI_read` in 1: I-cache line read request, level, held until `memI_ready`
- `memI_addr` in ADDR_W: I-cache line address
- `memI_rdata` out DATA_W: read data to I-cache
- `memI_ready` out 1: I-cache transaction complete, one-cycle pulse
- `memD_read` in 1: D-cache line read request
- `memD_write` in 1: D-cache line write-back request
- `memD_addr` in ADDR_W: D-cache line address
- `memD_wdata` in DATA_W: D-cache write-back data
- `memD_rdata` out DATA_W: read data to D-cache
- `memD_ready` out 1: D-cache transaction complete, one-cycle pulse
- `mem_read` out 1: memory read strobe, level
- `mem_write` out 1: memory write strobe, level
- `mem_addr` out ADDR_W: memory line address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ready`
- `mem_ready` in 1: memory completion, one-cycle pulse
- `arb_busy` out 1: high while a transaction is outstanding

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: no request pending -> stay. Otherwise pick the winner per the arbitration rule, latch its address, wdata and op (read/write) into request registers, and go to BUSY_I or BUSY_D.
- BUSY_x: drive the downstream port from the request registers. On `mem_ready`, return to IDLE and update `last_grant` to x.
- Downstream `mem_read`/`mem_write`/`mem_addr`/`mem_wdata` come from registers only. Requester inputs changing during BUSY have no effect.
- `memD_write` and `memD_read` both high: treated as a write, since a write-back precedes its refill.
- `memI_ready = mem_ready & BUSY_I`; `memD_ready = mem_ready & BUSY_D`. The non-granted requester never sees ready.
- `memI_rdata` and `memD_rdata` are both a combinational pass-through of `mem_rdata`. Each is meaningful only with its own ready.
- A requester that drops its request while granted does not cancel the transaction. It runs to `mem_ready`, and the ready pulse is still delivered.
- Default arbitration: D has fixed priority over I.
- `arb_busy` = state != IDLE.

## Timing
- Reset (`proc_reset` high at an edge), from any state: state IDLE, `last_grant`=I, request registers 0. Outputs `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `memI_ready`=0, `memD_ready`=0, `arb_busy`=0. `*_rdata` follow `mem_rdata`.
- Reset mid-transaction abandons that transaction. A `mem_ready` arriving while in IDLE is ignored: no ready to either requester.
- Grant latency: request first high in IDLE at cycle t -> downstream strobe high from cycle t+1.
- Completion: requester ready in the same cycle as `mem_ready`, with zero added latency. Strobe low in the following cycle.
- Every transaction is followed by at least one IDLE cycle with both strobes low. The cache sees ready, updates on the same edge, and its new request is sampled in that IDLE cycle.
- Minimum back-to-back spacing: memory latency + 2 cycles per transaction.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. When both request in IDLE, grant the requester that is not `last_grant`. After reset the first tie goes to D.
- `MEM_ARB_RR_EN` undefined: fixed D-over-I priority; `last_grant` is unused and may be optimized away.

## Test plan
- I-only read: `memI_addr`=0x0000010. Expect `mem_read`=1, `mem_addr`=0x0000010 next cycle. After 4 cycles drive `mem_ready` with `mem_rdata`=0xA5A5…A5. Expect `memI_ready`=1, `memI_rdata`=0xA5A5…A5, `memD_ready`=0; `mem_read`=0 the following cycle.
- D write-back: `memD_write`=1, `memD_addr`=0x0000200, `memD_wdata`=0x0123…CDEF. Expect `mem_write`=1, `mem_read`=0, exact wdata and address held until `mem_ready`; `memD_ready` pulses once.
- Simultaneous I and D requests, macro undefined: D served first; I's strobe rises 2 cycles after D's `mem_ready`. Repeat the tie: D again. With `MEM_ARB_RR_EN`: D, then I on the next tie.
- Change `memD_addr` from 0x0000200 to 0x0000300 during BUSY_D: `mem_addr` stays 0x0000200. `memD_read`+`memD_write` both high: `mem_write`=1 only.
- Assert `proc_reset` during BUSY_D, then `mem_ready` the cycle after: all outputs 0, `arb_busy`=0, no ready pulse to either requester.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-cache and D-cache refill/write-back paths.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              memI_read,
    input  logic [ADDR_W-1:0] memI_addr,
    output logic [DATA_W-1:0] memI_rdata,
    output logic              memI_ready,
    input  logic              memD_read,
    input  logic              memD_write,
    input  logic [ADDR_W-1:0] memD_addr,
    input  logic [DATA_W-1:0] memD_wdata,
    output logic [DATA_W-1:0] memD_rdata,
    output logic              memD_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_busy
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              w_d_req, w_pick_d, w_start;

    assign w_d_req = memD_read | memD_write;
    assign w_start = (r_state == IDLE) & (w_d_req | memI_read);

`ifdef MEM_ARB_RR_EN
    logic r_last_d;
    // On a tie, the requester that was not served last wins; reset leaves I as last so D wins first.
    assign w_pick_d = w_d_req & (~memI_read | ~r_last_d);

    always_ff @(posedge clk) begin
        if (proc_reset)
            r_last_d <= 1'b0;
        else if (r_state != IDLE && mem_ready)
            r_last_d <= (r_state == BUSY_D);
    end
`else
    assign w_pick_d = w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (proc_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_pick_d ? BUSY_D : (memI_read ? BUSY_I : IDLE);
        else if (mem_ready)
            w_next = IDLE;
    end

    // Request is frozen at grant; a simultaneous D read+write is a write-back first.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (w_start) begin
            r_addr  <= w_pick_d ? memD_addr : memI_addr;
            r_wdata <= w_pick_d ? memD_wdata : '0;
            r_write <= w_pick_d & memD_write;
        end
    end

    always_comb begin
        arb_busy   = (r_state != IDLE);
        mem_read   = arb_busy & ~r_write;
        mem_write  = arb_busy & r_write;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        memI_ready = mem_ready & (r_state == BUSY_I);
        memD_ready = mem_ready & (r_state == BUSY_D);
        memI_rdata = mem_rdata;
        memD_rdata = mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, hold, completion, tie-breaking and reset of mem_arbiter.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         memI_read;
    logic [27:0]  memI_addr;
    logic [127:0] memI_rdata;
    logic         memI_ready;
    logic         memD_read, memD_write;
    logic [27:0]  memD_addr;
    logic [127:0] memD_wdata, memD_rdata;
    logic         memD_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic         arb_busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] WD = {2{64'h0123456789ABCDEF}};

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .memI_read(memI_read), .memI_addr(memI_addr), .memI_rdata(memI_rdata), .memI_ready(memI_ready),
        .memD_read(memD_read), .memD_write(memD_write), .memD_addr(memD_addr), .memD_wdata(memD_wdata),
        .memD_rdata(memD_rdata), .memD_ready(memD_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_rd"}, 128'(mem_read), 128'd0);
        chk({tag, "_wr"}, 128'(mem_write), 128'd0);
        chk({tag, "_busy"}, 128'(arb_busy), 128'd0);
        chk({tag, "_irdy"}, 128'(memI_ready), 128'd0);
        chk({tag, "_drdy"}, 128'(memD_ready), 128'd0);
    endtask

    initial begin
        proc_reset = 1; memI_read = 0; memI_addr = 0; memD_read = 0; memD_write = 0;
        memD_addr = 0; memD_wdata = 0; mem_rdata = 128'h5A; mem_ready = 0;
        tick; tick;
        idle_outputs("rst");
        chk("rst_addr", 128'(mem_addr), 128'd0);
        chk("rst_wdata", mem_wdata, 128'd0);
        chk("rst_irdata", memI_rdata, 128'h5A);
        chk("rst_drdata", memD_rdata, 128'h5A);
        proc_reset = 0;

        // I-only read
        memI_read = 1; memI_addr = 28'h0000010;
        tick;
        chk("i_rd", 128'(mem_read), 128'd1);
        chk("i_wr", 128'(mem_write), 128'd0);
        chk("i_addr", 128'(mem_addr), 128'h10);
        chk("i_busy", 128'(arb_busy), 128'd1);
        memI_addr = 28'h0000999;
        tick; tick; tick;
        chk("i_addr_hold", 128'(mem_addr), 128'h10);
        chk("i_no_early_rdy", 128'(memI_ready), 128'd0);
        mem_ready = 1; mem_rdata = A5;
        #1;
        chk("i_rdy", 128'(memI_ready), 128'd1);
        chk("i_rdata", memI_rdata, A5);
        chk("i_d_rdy", 128'(memD_ready), 128'd0);
        tick;
        mem_ready = 0; memI_read = 0;
        idle_outputs("i_after");

        // D write-back, address/data held against requester changes
        memD_write = 1; memD_addr = 28'h0000200; memD_wdata = WD;
        tick;
        chk("d_wr", 128'(mem_write), 128'd1);
        chk("d_rd", 128'(mem_read), 128'd0);
        chk("d_addr", 128'(mem_addr), 128'h200);
        chk("d_wdata", mem_wdata, WD);
        memD_addr = 28'h0000300; memD_wdata = ~WD;
        tick; tick;
        chk("d_addr_hold", 128'(mem_addr), 128'h200);
        chk("d_wdata_hold", mem_wdata, WD);
        chk("d_wr_hold", 128'(mem_write), 128'd1);
        mem_ready = 1;
        #1;
        chk("d_rdy", 128'(memD_ready), 128'd1);
        chk("d_i_rdy", 128'(memI_ready), 128'd0);
        tick;
        mem_ready = 0; memD_write = 0;
        idle_outputs("d_after");

        // D read+write together is a write
        memD_read = 1; memD_write = 1; memD_addr = 28'h0000040;
        tick;
        chk("rw_wr", 128'(mem_write), 128'd1);
        chk("rw_rd", 128'(mem_read), 128'd0);
        mem_ready = 1;
        tick;
        mem_ready = 0; memD_read = 0; memD_write = 0;
        chk("rw_done", 128'(arb_busy), 128'd0);

        // fresh reset so the first tie sees last_grant = I
        proc_reset = 1;
        tick;
        proc_reset = 0;

        // tie 1: D first, I strobe two cycles after D's ready
        memI_read = 1; memI_addr = 28'h0000010; memD_read = 1; memD_addr = 28'h0000500;
        tick;
        chk("t1_addr", 128'(mem_addr), 128'h500);
        chk("t1_rd", 128'(mem_read), 128'd1);
        mem_ready = 1;
        #1;
        chk("t1_drdy", 128'(memD_ready), 128'd1);
        chk("t1_irdy", 128'(memI_ready), 128'd0);
        tick;
        mem_ready = 0; memD_read = 0;
        chk("t1_gap_rd", 128'(mem_read), 128'd0);
        chk("t1_gap_busy", 128'(arb_busy), 128'd0);
        tick;
        chk("t1_i_rd", 128'(mem_read), 128'd1);
        chk("t1_i_addr", 128'(mem_addr), 128'h10);
        mem_ready = 1;
        #1;
        chk("t1_i_rdy", 128'(memI_ready), 128'd1);
        tick;
        mem_ready = 0;

        // tie 2: last grant was I, D wins in both modes; both keep requesting
        memD_read = 1;
        tick;
        chk("t2_addr", 128'(mem_addr), 128'h500);
        mem_ready = 1;
        tick;
        mem_ready = 0;
        tick;
`ifdef MEM_ARB_RR_EN
        chk("t3_addr", 128'(mem_addr), 128'h10);
`else
        chk("t3_addr", 128'(mem_addr), 128'h500);
`endif
        mem_ready = 1;
        tick;
        mem_ready = 0; memI_read = 0; memD_read = 0;
        tick;

        // reset during BUSY_D, then a stray mem_ready in IDLE
        memD_write = 1; memD_addr = 28'h0000700; memD_wdata = WD;
        tick;
        chk("r_busy", 128'(arb_busy), 128'd1);
        proc_reset = 1; memD_write = 0;
        tick;
        proc_reset = 0; mem_ready = 1;
        #1;
        idle_outputs("r_mid");
        chk("r_addr", 128'(mem_addr), 128'd0);
        chk("r_wdata", mem_wdata, 128'd0);
        tick;
        mem_ready = 0;
        chk("r_stay_idle", 128'(arb_busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
